pong_paddle_gen: RTL and testbench

- Parametrised second-generation paddle block for the pong display pipeline.
- Owns the paddle's horizontal position: button-driven motion with acceleration, braking and wall clamping, updated once per frame.
- Renders the paddle into the RGB565 pixel stream with 1-cycle latency.
- Reports ball/paddle contact with a hit zone, so the ball logic can pick a rebound angle.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_paddle_motion.sv | 121 ++++++++++++
 rtl/pong_paddle_gen.sv | 114 +++++++++++
 tb/tb_pong_paddle_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and encodings for the pong display pipeline.
package pong_pkg;

  // Visible screen area
  localparam int unsigned H_ACT = 640;
  localparam int unsigned V_ACT = 480;

  // RGB565 colours
  localparam logic [15:0] ColorBlack = 16'h0000;
  localparam logic [15:0] ColorWhite = 16'hFFFF;
  localparam logic [15:0] ColorRed   = 16'hF800;

  // Paddle motion states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMoveL = 2'd1,
    StMoveR = 2'd2,
    StBrake = 2'd3
  } motion_state_e;

  // Ball contact zone on the paddle
  typedef enum logic [1:0] {
    ZoneNone   = 2'd0,
    ZoneLeft   = 2'd1,
    ZoneCentre = 2'd2,
    ZoneRight  = 2'd3
  } hit_zone_e;

endpackage

// File: rtl/pong_paddle_motion.sv
// Paddle motion: button-driven acceleration, braking and wall clamping.
// Position and speed change only on frame_start so the paddle never tears.
module pong_paddle_motion
  import pong_pkg::*;
#(
  parameter int unsigned HAct     = H_ACT,
  parameter int unsigned PaddleW  = 40,
  parameter int unsigned XInit    = 320,
  parameter int unsigned MaxSpeed = 8,
  parameter int unsigned AccelDiv = 4
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       frame_start,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] paddle_x
);

  localparam logic [3:0] SpeedMax = 4'(MaxSpeed);
  localparam logic [3:0] CntLast  = 4'(AccelDiv - 1);
  // The frame that starts a move already counts toward the first speed step
  localparam logic [3:0] CntStart = (AccelDiv > 1) ? 4'd1 : 4'd0;
  localparam logic [9:0] XReset   = 10'(XInit);
  localparam logic signed [10:0] XMin = 11'(PaddleW / 2);
  localparam logic signed [10:0] XMax = 11'(HAct - PaddleW / 2);

  motion_state_e      state_q, state_d;
  logic [3:0]         speed_q, speed_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;  // 1 = right
  logic [9:0]         x_q, x_d;

  logic               req_l, req_r, same_dir;
  logic signed [10:0] x_ext, step, x_next;

  // Next-state, speed and position, evaluated once per frame
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    x_d      = x_q;
    x_ext    = '0;
    step     = '0;
    x_next   = '0;
    req_l    = btn_left & ~btn_right;
    req_r    = btn_right & ~btn_left;
    same_dir = dir_q ? req_r : req_l;

    if (frame_start) begin
      unique case (state_q)
        StIdle: begin
          if (req_l | req_r) begin
            state_d = req_r ? StMoveR : StMoveL;
            dir_d   = req_r;
            speed_d = 4'd1;
            cnt_d   = CntStart;
          end
        end
        StMoveL, StMoveR: begin
          if (same_dir) begin
            if (cnt_q >= CntLast) begin
              cnt_d = '0;
              if (speed_q < SpeedMax) speed_d = speed_q + 4'd1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d   = '0;
            speed_d = (speed_q > 4'd1) ? speed_q - 4'd1 : 4'd0;
            state_d = (speed_q > 4'd1) ? StBrake : StIdle;
          end
        end
        StBrake: begin
          // Opposite requests wait until the paddle has stopped
          if (same_dir) begin
            state_d = dir_q ? StMoveR : StMoveL;
          end else begin
            speed_d = (speed_q > 4'd1) ? speed_q - 4'd1 : 4'd0;
            state_d = (speed_q > 4'd1) ? StBrake : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      x_ext  = $signed({1'b0, x_q});
      step   = $signed({7'd0, speed_d});
      x_next = dir_d ? x_ext + step : x_ext - step;

      if (x_next < XMin || x_next > XMax) begin
        x_d     = (x_next < XMin) ? XMin[9:0] : XMax[9:0];
        speed_d = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        x_d = x_next[9:0];
      end
    end
  end

  // Motion state registers
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      speed_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      x_q     <= XReset;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
    end
  end

  assign paddle_x = x_q;

endmodule

// File: rtl/pong_paddle_gen.sv
// Paddle generator: owns paddle position, renders it into the RGB565 stream
// and reports ball contact with a hit zone. Render and hit are registered.
// Optional macro PONG_PADDLE_BORDER_EN draws a 2-pixel border in BorderColor.
module pong_paddle_gen
  import pong_pkg::*;
#(
  parameter int unsigned HAct     = H_ACT,
  parameter int unsigned PaddleW  = 40,
  parameter int unsigned PaddleH  = 100,
  parameter int unsigned PaddleY  = 420,
  parameter int unsigned XInit    = 320,
  parameter int unsigned MaxSpeed = 8,
  parameter int unsigned AccelDiv = 4,
`ifdef PONG_PADDLE_BORDER_EN
  parameter logic [15:0] BorderColor = ColorRed,
`endif
  parameter logic [15:0] Color    = ColorWhite
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  output logic [9:0]  paddle_x,
  output logic [15:0] pix_data,
  output logic        paddle_hit,
  output logic [1:0]  hit_zone
);

  localparam logic [10:0] HalfW  = 11'(PaddleW / 2);
  localparam logic [10:0] YTop   = 11'(PaddleY);
  localparam logic [10:0] YEnd   = 11'(PaddleY + PaddleH);
  localparam logic [10:0] ZoneLo = 11'(PaddleW / 3);
  localparam logic [10:0] ZoneHi = 11'(PaddleW - PaddleW / 3);

  logic [15:0] pix_data_q, pix_data_d;
  logic        hit_q, hit_d;
  logic [1:0]  zone_q, zone_d;

  logic [10:0] px, py, bx, by, pl, ball_off;
  logic        in_pix, in_ball;
`ifdef PONG_PADDLE_BORDER_EN
  logic [10:0] pix_dx, pix_dy;
  logic        on_edge;
`endif

  pong_paddle_motion #(
    .HAct     (HAct),
    .PaddleW  (PaddleW),
    .XInit    (XInit),
    .MaxSpeed (MaxSpeed),
    .AccelDiv (AccelDiv)
  ) u_motion (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .paddle_x    (paddle_x)
  );

  // Render and hit comparators; all 11-bit so the left edge never underflows
  always_comb begin
    px       = {1'b0, pix_x};
    py       = {1'b0, pix_y};
    bx       = {1'b0, ball_x};
    by       = {1'b0, ball_y};
    pl       = {1'b0, paddle_x};
    in_pix   = (py >= YTop) && (py < YEnd) && (pl <= px + HalfW) && (px < pl + HalfW);
    in_ball  = (by >= YTop) && (by < YEnd) && (pl <= bx + HalfW) && (bx < pl + HalfW);
    ball_off = bx + HalfW - pl;

    pix_data_d = ColorBlack;
`ifdef PONG_PADDLE_BORDER_EN
    pix_dx  = px + HalfW - pl;
    pix_dy  = py - YTop;
    on_edge = (pix_dx < 11'd2) || (pix_dx >= 11'(PaddleW - 2)) ||
              (pix_dy < 11'd2) || (pix_dy >= 11'(PaddleH - 2));
    if (in_pix) pix_data_d = on_edge ? BorderColor : Color;
`else
    if (in_pix) pix_data_d = Color;
`endif

    hit_d  = in_ball;
    zone_d = ZoneNone;
    if (in_ball) begin
      if (ball_off < ZoneLo)       zone_d = ZoneLeft;
      else if (ball_off >= ZoneHi) zone_d = ZoneRight;
      else                         zone_d = ZoneCentre;
    end
  end

  // Output registers (1-cycle latency)
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      pix_data_q <= ColorBlack;
      hit_q      <= 1'b0;
      zone_q     <= ZoneNone;
    end else begin
      pix_data_q <= pix_data_d;
      hit_q      <= hit_d;
      zone_q     <= zone_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign paddle_hit = hit_q;
  assign hit_zone   = zone_q;

endmodule

// File: tb/tb_pong_paddle_gen.sv
// Directed bench for pong_paddle_gen with default parameters.
module tb_pong_paddle_gen;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [9:0]  ball_x = '0;
  logic [9:0]  ball_y = '0;
  logic [9:0]  paddle_x;
  logic [15:0] pix_data;
  logic        paddle_hit;
  logic [1:0]  hit_zone;

  int checks = 0;
  int errors = 0;

  pong_paddle_gen dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .paddle_x    (paddle_x),
    .pix_data    (pix_data),
    .paddle_hit  (paddle_hit),
    .hit_zone    (hit_zone)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge vga_clk) frame_start = 1'b1;
    @(negedge vga_clk) frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic probe_pix(input int x, input int y);
    @(negedge vga_clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(negedge vga_clk);
  endtask

  task automatic probe_ball(input int x, input int y);
    @(negedge vga_clk);
    ball_x = 10'(x);
    ball_y = 10'(y);
    @(negedge vga_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_r[10] = '{321, 322, 323, 325, 327, 329, 331, 334, 337, 340};

    // Reset
    repeat (3) @(negedge vga_clk);
    sys_rst = 1'b0;
    check("rst_x", 16'(paddle_x), 16'd320);
    check("rst_pix", pix_data, 16'h0000);
    check("rst_hit", 16'(paddle_hit), 16'd0);
    check("rst_zone", 16'(hit_zone), 16'd0);

    // Idle frames and basic render
    frames(5);
    check("idle_x", 16'(paddle_x), 16'd320);
    probe_pix(0, 0);     check("pix_0_0", pix_data, 16'h0000);
    probe_pix(300, 420); check("pix_300_420", pix_data, 16'hFFFF);
    probe_pix(340, 420); check("pix_340_420", pix_data, 16'h0000);

    // Acceleration to the right
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("accel_r%0d", i), 16'(paddle_x), 16'(exp_r[i]));
    end

    // Release: brake 2, 1, then stop
    btn_right = 1'b0;
    frame(); check("brake1", 16'(paddle_x), 16'd342);
    frame(); check("brake2", 16'(paddle_x), 16'd343);
    frame(); check("brake3", 16'(paddle_x), 16'd343);

    // Both buttons cancel
    btn_left = 1'b1;
    btn_right = 1'b1;
    frames(8);
    check("both_x", 16'(paddle_x), 16'd343);

    // No motion between frame pulses
    btn_left = 1'b0;
    repeat (6) @(negedge vga_clk);
    check("stable_x", 16'(paddle_x), 16'd343);

    // Left for 16 frames: speed reaches 5, x = 343 - 44
    btn_right = 1'b0;
    btn_left  = 1'b1;
    frames(16);
    check("left16_x", 16'(paddle_x), 16'd299);

    // Reset mid-move, coinciding with frame_start, with paddle content visible
    @(negedge vga_clk);
    pix_x = 10'd300; pix_y = 10'd430;
    ball_x = 10'd300; ball_y = 10'd430;
    @(negedge vga_clk);
    check("pre_rst_pix", pix_data, 16'hFFFF);
    check("pre_rst_zone", 16'(hit_zone), 16'd2);
    sys_rst = 1'b1;
    frame_start = 1'b1;
    @(negedge vga_clk);
    check("mid_rst_x", 16'(paddle_x), 16'd320);
    check("mid_rst_pix", pix_data, 16'h0000);
    check("mid_rst_hit", 16'(paddle_hit), 16'd0);
    check("mid_rst_zone", 16'(hit_zone), 16'd0);
    sys_rst = 1'b0;
    frame_start = 1'b0;
    btn_left = 1'b0;

    // Render boundaries at paddle_x = 320 (span 300..339, rows 420..519)
    probe_pix(339, 519); check("pix_339_519", pix_data, 16'hFFFF);
    probe_pix(299, 420); check("pix_299_420", pix_data, 16'h0000);
    probe_pix(320, 520); check("pix_320_520", pix_data, 16'h0000);
    probe_pix(320, 419); check("pix_320_419", pix_data, 16'h0000);

    // Hit zones: thirds at 13 and 27
    probe_ball(300, 430);
    check("hit_300", 16'(paddle_hit), 16'd1); check("zone_300", 16'(hit_zone), 16'd1);
    probe_ball(312, 430); check("zone_312", 16'(hit_zone), 16'd1);
    probe_ball(313, 430); check("zone_313", 16'(hit_zone), 16'd2);
    probe_ball(320, 430); check("zone_320", 16'(hit_zone), 16'd2);
    probe_ball(326, 430); check("zone_326", 16'(hit_zone), 16'd2);
    probe_ball(327, 430); check("zone_327", 16'(hit_zone), 16'd3);
    probe_ball(339, 430); check("zone_339", 16'(hit_zone), 16'd3);
    probe_ball(345, 430);
    check("hit_345", 16'(paddle_hit), 16'd0); check("zone_345", 16'(hit_zone), 16'd0);
    probe_ball(320, 419); check("hit_y419", 16'(paddle_hit), 16'd0);
    probe_ball(320, 519); check("hit_y519", 16'(paddle_hit), 16'd1);

    // Speed was cleared by reset
    frame();
    check("post_rst_idle", 16'(paddle_x), 16'd320);

    // Left to the wall: restart at speed 1, saturate at 8, clamp at 20
    btn_left = 1'b1;
    frame();     check("wall_f1", 16'(paddle_x), 16'd319);
    frames(26);  check("wall_f27", 16'(paddle_x), 16'd209);
    frames(23);  check("wall_f50", 16'(paddle_x), 16'd25);
    frame();     check("clamp_x", 16'(paddle_x), 16'd20);
    frame();     check("clamp_again", 16'(paddle_x), 16'd20);

    // Left edge render/hit with no underflow (span 0..39)
    probe_pix(0, 420);   check("pix_edge0", pix_data, 16'hFFFF);
    probe_pix(40, 420);  check("pix_edge40", pix_data, 16'h0000);
    probe_ball(0, 430);  check("zone_edge0", 16'(hit_zone), 16'd1);

    // Clamp cleared speed: new move starts at 1
    btn_left  = 1'b0;
    btn_right = 1'b1;
    frame();     check("after_clamp", 16'(paddle_x), 16'd21);
    btn_right = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
